// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared definitions for the RV32I memory stage.
//   - funct3 encodings for loads and stores
//   - memory-stage FSM state type
//   - helpers: byte-enable generation, funct3 legality, misalignment test
package rv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  // Lane enables; funct3[1:0] gives the size for both loads and stores.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   byte_en = 4'b0001 << a;
      2'b01:   byte_en = 4'b0011 << {a[1], 1'b0};
      default: byte_en = 4'hF;
    endcase
  endfunction

  // funct3 values 3, 6 and 7 have no RV32I load/store meaning.
  function automatic logic f3_legal(input logic [2:0] f3);
    f3_legal = !((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv_mem_access_align.sv
// rv_mem_access_align (module rv_mem_align): combinational lane logic.
//   funct3     in  3   access size / sign
//   addr_lo    in  2   byte address bits [1:0]
//   store_data in  32  rs2 value
//   bus_rdata  in  32  raw read word
//   be         out 4   byte enables
//   wdata      out 32  lane-replicated store data
//   load_data  out 32  selected and extended load value
module rv_mem_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign be = byte_en(funct3, addr_lo);

  always_comb begin
    case (funct3[1:0])
      2'b00:   wdata = {4{store_data[7:0]}};
      2'b01:   wdata = {2{store_data[15:0]}};
      default: wdata = store_data;
    endcase
  end

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
  end

  // Halves pick on a[1] only, so an unchecked odd address reads the containing half.
  assign half_sel = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  // funct3[2] marks the unsigned variants (LBU/LHU).
  always_comb begin
    case (funct3[1:0])
      2'b00:   load_data = {{24{byte_sel[7] & ~funct3[2]}}, byte_sel};
      2'b01:   load_data = {{16{half_sel[15] & ~funct3[2]}}, half_sel};
      default: load_data = bus_rdata;
    endcase
  end

endmodule

// File: rtl/rv_mem_access.sv
// rv_mem_access: memory stage of the 5-stage RV32I pipeline.
// Registers execute results, runs the data-bus access for loads/stores,
// extends load data and stalls the pipeline while the bus is busy.
// Optional build macro: RV_MEM_MISALIGN_CHECK_EN (misaligned half/word
// accesses are dropped with a fault pulse instead of being issued).
// Ports:
//   i_clk, i_reset_n                    clock, async active-low reset
//   i_alu_result/i_rs2_val/i_rd/...     execute-stage inputs
//   o_bus_req/we/addr/be/wdata          data-bus request side
//   i_bus_ack, i_bus_rdata              data-bus response side
//   o_stall                             hold upstream stages and this input register
//   o_memory_rd_val                     bypass value to execute
//   o_alu_result/o_rd/o_reg_write/o_res_src/o_pc_p4/o_read_data  to write-back
//   o_fault                             one-cycle fault pulse
module rv_mem_access
  import rv_mem_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_rs2_val,
  input  logic [4:0]  i_rd,
  input  logic        i_reg_write,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [1:0]  i_res_src,
  input  logic [2:0]  i_funct3,
  input  logic [29:0] i_pc_p4,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [29:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_stall,
  output logic [31:0] o_memory_rd_val,
  output logic [31:0] o_alu_result,
  output logic [4:0]  o_rd,
  output logic        o_reg_write,
  output logic [1:0]  o_res_src,
  output logic [29:0] o_pc_p4,
  output logic [31:0] o_read_data,
  output logic        o_fault
);

  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  state_t        state_reg;
  logic [CW-1:0] wait_cnt_reg;
  logic          timeout_fault_reg;

  logic [31:0] alu_result_reg;
  logic [31:0] rs2_reg;
  logic [4:0]  rd_reg;
  logic        reg_write_reg;
  logic        mem_read_reg;
  logic        mem_write_reg;
  logic [1:0]  res_src_reg;
  logic [2:0]  funct3_reg;
  logic [29:0] pc_p4_reg;

  logic        access;
  logic        timeout;
  logic        in_misalign;
  logic        in_issue;
  logic        stg_mem;
  logic        stg_illegal;
  logic        stg_misalign;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;

`ifdef RV_MEM_MISALIGN_CHECK_EN
  assign in_misalign  = misaligned(i_funct3, i_alu_result[1:0]);
  assign stg_misalign = stg_mem & f3_legal(funct3_reg) &
                        misaligned(funct3_reg, alu_result_reg[1:0]);
`else
  assign in_misalign  = 1'b0;
  assign stg_misalign = 1'b0;
`endif

  assign access      = (state_reg == S_ACCESS);
  assign in_issue    = (i_mem_read | i_mem_write) & f3_legal(i_funct3) & ~in_misalign;
  assign stg_mem     = mem_read_reg | mem_write_reg;
  assign stg_illegal = stg_mem & ~f3_legal(funct3_reg);
  // Abort on the cycle that would bring the un-acked count up to WAIT_MAX.
  assign timeout     = access & ~i_bus_ack & (wait_cnt_reg == CW'(WAIT_MAX - 1));
  assign o_stall     = access & ~i_bus_ack;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg         <= S_IDLE;
      wait_cnt_reg      <= '0;
      timeout_fault_reg <= 1'b0;
      alu_result_reg    <= '0;
      rs2_reg           <= '0;
      rd_reg            <= '0;
      reg_write_reg     <= 1'b0;
      mem_read_reg      <= 1'b0;
      mem_write_reg     <= 1'b0;
      res_src_reg       <= '0;
      funct3_reg        <= '0;
      pc_p4_reg         <= '0;
    end else begin
      timeout_fault_reg <= timeout;
      if (!o_stall) begin
        alu_result_reg <= i_alu_result;
        rs2_reg        <= i_rs2_val;
        rd_reg         <= i_rd;
        reg_write_reg  <= i_reg_write;
        mem_read_reg   <= i_mem_read;
        mem_write_reg  <= i_mem_write;
        res_src_reg    <= i_res_src;
        funct3_reg     <= i_funct3;
        pc_p4_reg      <= i_pc_p4;
        state_reg      <= in_issue ? S_ACCESS : S_IDLE;
        wait_cnt_reg   <= '0;
      end else if (timeout) begin
        // Stage register keeps the aborted op for one more cycle so the
        // fault cycle can squash its write-back.
        state_reg <= S_IDLE;
      end else begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
    end
  end

  rv_mem_align u_align (
    .funct3     (funct3_reg),
    .addr_lo    (alu_result_reg[1:0]),
    .store_data (rs2_reg),
    .bus_rdata  (i_bus_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (load_data)
  );

  assign o_bus_req   = access;
  assign o_bus_we    = access & mem_write_reg;
  assign o_bus_addr  = access ? alu_result_reg[31:2] : '0;
  assign o_bus_be    = access ? lane_be : '0;
  assign o_bus_wdata = (access & mem_write_reg) ? lane_wdata : '0;

  assign o_read_data     = (access & i_bus_ack & mem_read_reg) ? load_data : '0;
  assign o_memory_rd_val = alu_result_reg;
  assign o_alu_result    = alu_result_reg;
  assign o_rd            = rd_reg;
  assign o_res_src       = res_src_reg;
  assign o_pc_p4         = pc_p4_reg;
  assign o_reg_write     = reg_write_reg & ~(timeout_fault_reg | stg_illegal | stg_misalign);
  assign o_fault         = timeout_fault_reg | stg_misalign;

endmodule

// File: tb/tb_rv_mem_access.sv
// Directed bench for rv_mem_access (instantiated with WAIT_MAX=4).
module tb_rv_mem_access;
  import rv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] alu_result, rs2_val, bus_rdata;
  logic [4:0]  rd;
  logic        reg_write, mem_read, mem_write, bus_ack;
  logic [1:0]  res_src;
  logic [2:0]  funct3;
  logic [29:0] pc_p4;

  logic        bus_req, bus_we, stall, reg_write_o, fault;
  logic [29:0] bus_addr, pc_p4_o;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata, memory_rd_val, alu_result_o, read_data;
  logic [4:0]  rd_o;
  logic [1:0]  res_src_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rv_mem_access #(.WAIT_MAX(4)) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_alu_result(alu_result), .i_rs2_val(rs2_val), .i_rd(rd),
    .i_reg_write(reg_write), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .i_res_src(res_src), .i_funct3(funct3), .i_pc_p4(pc_p4),
    .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
    .o_bus_be(bus_be), .o_bus_wdata(bus_wdata),
    .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata),
    .o_stall(stall), .o_memory_rd_val(memory_rd_val),
    .o_alu_result(alu_result_o), .o_rd(rd_o), .o_reg_write(reg_write_o),
    .o_res_src(res_src_o), .o_pc_p4(pc_p4_o),
    .o_read_data(read_data), .o_fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] r2, input logic [4:0] d,
                        input logic rw, input logic mr, input logic mw,
                        input logic [2:0] f3, input logic [29:0] pc);
    alu_result = a; rs2_val = r2; rd = d; reg_write = rw;
    mem_read = mr; mem_write = mw; res_src = 2'd0; funct3 = f3; pc_p4 = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 30'h0);
    step(); step();
    check("rst_req", 32'(bus_req), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_alu", alu_result_o, 32'h0);
    check("rst_rw", 32'(reg_write_o), 32'h0);
    check("rst_be", 32'(bus_be), 32'h0);
    reset_n = 1'b1;

    // 1: SW, same-cycle ack
    set_op(32'h100, 32'hDEADBEEF, 5'd5, 1'b0, 1'b0, 1'b1, F3_SW, 30'h11);
    step();
    check("sw_req", 32'(bus_req), 32'h1);
    check("sw_we", 32'(bus_we), 32'h1);
    check("sw_be", 32'(bus_be), 32'hF);
    check("sw_addr", 32'(bus_addr), 32'h40);
    check("sw_wdata", bus_wdata, 32'hDEADBEEF);
    check("sw_pc", 32'(pc_p4_o), 32'h11);
    bus_ack = 1'b1; #1;
    check("sw_stall", 32'(stall), 32'h0);
    set_op(32'h55, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 3'd0, 30'h22);
    step();
    bus_ack = 1'b0; #1;
    check("alu_req", 32'(bus_req), 32'h0);
    check("alu_res", alu_result_o, 32'h55);
    check("alu_byp", memory_rd_val, 32'h55);
    check("alu_rd", 32'(rd_o), 32'h7);
    check("alu_rw", 32'(reg_write_o), 32'h1);
    check("alu_rdata", read_data, 32'h0);

    // 2: SB, ack on the fourth access cycle
    set_op(32'h103, 32'h12, 5'd3, 1'b0, 1'b0, 1'b1, F3_SB, 30'h0);
    step();
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 30'h0);
    check("sb_be", 32'(bus_be), 32'h8);
    check("sb_wdata", bus_wdata, 32'h12121212);
    check("sb_addr", 32'(bus_addr), 32'h40);
    check("sb_stall1", 32'(stall), 32'h1);
    step();
    check("sb_stall2", 32'(stall), 32'h1);
    check("sb_hold", alu_result_o, 32'h103);
    step();
    check("sb_stall3", 32'(stall), 32'h1);
    step();
    bus_ack = 1'b1; #1;
    check("sb_stall4", 32'(stall), 32'h0);
    check("sb_req4", 32'(bus_req), 32'h1);
    step();
    bus_ack = 1'b0; #1;
    check("sb_done", 32'(bus_req), 32'h0);

    // 3: back-to-back loads
    set_op(32'h201, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, F3_LB, 30'h0);
    step();
    check("lb_be", 32'(bus_be), 32'h2);
    check("lb_we", 32'(bus_we), 32'h0);
    check("lb_addr", 32'(bus_addr), 32'h80);
    bus_rdata = 32'h000080FF; bus_ack = 1'b1; #1;
    check("lb_data", read_data, 32'hFFFFFF80);
    check("lb_rw", 32'(reg_write_o), 32'h1);
    set_op(32'h201, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, F3_LBU, 30'h0);
    step();
    check("lbu_req", 32'(bus_req), 32'h1);
    check("lbu_data", read_data, 32'h00000080);
    set_op(32'h202, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, F3_LH, 30'h0);
    step();
    bus_rdata = 32'h80010000; #1;
    check("lh_be", 32'(bus_be), 32'hC);
    check("lh_data", read_data, 32'hFFFF8001);
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 30'h0);
    step();
    bus_ack = 1'b0; #1;
    check("ld_done", 32'(bus_req), 32'h0);

    // 4: timeout after WAIT_MAX=4 cycles
    set_op(32'h300, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, F3_LW, 30'h0);
    step();
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 30'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_req%0d", i), 32'(bus_req), 32'h1);
      check($sformatf("to_stall%0d", i), 32'(stall), 32'h1);
      step();
    end
    check("to_req_drop", 32'(bus_req), 32'h0);
    check("to_fault", 32'(fault), 32'h1);
    check("to_rw", 32'(reg_write_o), 32'h0);
    check("to_stall_rel", 32'(stall), 32'h0);
    step();
    check("to_fault_end", 32'(fault), 32'h0);
    check("to_next", alu_result_o, 32'h0);

    // 5: misaligned LW
    set_op(32'h102, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, F3_LW, 30'h0);
    step();
`ifdef RV_MEM_MISALIGN_CHECK_EN
    check("mis_req", 32'(bus_req), 32'h0);
    check("mis_fault", 32'(fault), 32'h1);
    check("mis_rw", 32'(reg_write_o), 32'h0);
    check("mis_stall", 32'(stall), 32'h0);
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 30'h0);
    step();
    check("mis_fault_end", 32'(fault), 32'h0);
`else
    check("mis_req", 32'(bus_req), 32'h1);
    check("mis_be", 32'(bus_be), 32'hF);
    check("mis_addr", 32'(bus_addr), 32'h40);
    check("mis_fault", 32'(fault), 32'h0);
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 30'h0);
    bus_rdata = 32'hCAFEF00D; bus_ack = 1'b1; #1;
    check("mis_data", read_data, 32'hCAFEF00D);
    step();
    bus_ack = 1'b0; #1;
`endif

    // 7: illegal funct3 with a load
    set_op(32'h500, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'd3, 30'h0);
    step();
    check("ill_req", 32'(bus_req), 32'h0);
    check("ill_rw", 32'(reg_write_o), 32'h0);
    check("ill_stall", 32'(stall), 32'h0);
    check("ill_rdata", read_data, 32'h0);

    // 6: async reset during a stalled load
    set_op(32'h400, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, F3_LW, 30'h0);
    step();
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 30'h0);
    step();
    check("ar_pre_req", 32'(bus_req), 32'h1);
    reset_n = 1'b0; #1;
    check("ar_req", 32'(bus_req), 32'h0);
    check("ar_stall", 32'(stall), 32'h0);
    check("ar_alu", alu_result_o, 32'h0);
    check("ar_rw", 32'(reg_write_o), 32'h0);
    step();
    reset_n = 1'b1;
    set_op(32'h77, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0, 30'h0);
    step();
    check("ar_idle_req", 32'(bus_req), 32'h0);
    check("ar_idle_alu", alu_result_o, 32'h77);
    check("ar_idle_stall", 32'(stall), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
